// File: rtl/crc_checker_if.sv
// Handshake and operand bundle between the link receiver and the CRC checker.
interface crc_checker_if #(
  parameter int CRC_GPW_MAX = 8,
  parameter int DWIDTH      = 16
);
  logic                   ctrlEn;
  logic [DWIDTH-1:0]      dataIn;
  logic [CRC_GPW_MAX-1:0] crcIn;
  logic [CRC_GPW_MAX-1:0] GenPoly;
  logic [CRC_GPW_MAX-1:0] initVal;
  logic                   crcBusy;
  logic                   crcReady;
  logic                   crcOk;
  logic                   crcErr;
  logic [CRC_GPW_MAX-1:0] residue;

  modport master (
    output ctrlEn, dataIn, crcIn, GenPoly, initVal,
    input  crcBusy, crcReady, crcOk, crcErr, residue
  );

  modport slave (
    input  ctrlEn, dataIn, crcIn, GenPoly, initVal,
    output crcBusy, crcReady, crcOk, crcErr, residue
  );
endinterface

// File: rtl/crc_checker.sv
// Bit-serial CRC checker: divides {message, received CRC} MSB-first by the
// supplied generator polynomial and reports whether the remainder is zero.
module crc_checker #(
  parameter int CRC_GPW_MAX = 8,
  parameter int DWIDTH      = 16
) (
  input logic           clk,
  input logic           rstN,
  crc_checker_if.slave  crcIf
);
  localparam int DW = (CRC_GPW_MAX > 2) ? $clog2(CRC_GPW_MAX) : 1;
  localparam int SW = DWIDTH + CRC_GPW_MAX;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Index of the highest set bit at or above bit 1 (0 means no usable degree).
  function automatic logic [DW-1:0] polyDegree(input logic [CRC_GPW_MAX-1:0] p);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 1; i < CRC_GPW_MAX; i++) begin
      d = p[i] ? DW'(i) : d;
    end
    return d;
  endfunction

  // Mask with the low n bits set.
  function automatic logic [CRC_GPW_MAX-1:0] lowMask(input logic [DW-1:0] n);
    logic [CRC_GPW_MAX-1:0] m;
    for (int i = 0; i < CRC_GPW_MAX; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  state_t                 state_r;
  logic [DW-1:0]          deg_r;
  logic [CRC_GPW_MAX-1:0] mask_r;
  logic [CRC_GPW_MAX-1:0] taps_r;
  logic [CRC_GPW_MAX-1:0] rem_r;
  logic [SW-1:0]          stream_r;
  logic [CW-1:0]          bitCnt_r;
  logic                   valid_r;
  logic                   holdDone_r;
  logic                   busy_r;
  logic                   ready_r;
  logic                   ok_r;
  logic                   err_r;
  logic [CRC_GPW_MAX-1:0] residue_r;

  logic [DW-1:0]          startDeg_s;
  logic                   startValid_s;
  logic [CRC_GPW_MAX-1:0] startMask_s;
  logic [CRC_GPW_MAX-1:0] startCrc_s;
  logic                   fb_s;
  logic [CRC_GPW_MAX-1:0] nextRem_s;
  logic [CW-1:0]          lastCnt_s;

  // Decode the incoming polynomial and left-align the N received CRC bits
  // directly under the message so the stream can simply shift out its MSB.
  always_comb begin
    startDeg_s   = polyDegree(crcIf.GenPoly);
    startValid_s = (crcIf.GenPoly[CRC_GPW_MAX-1:1] != '0);
    startMask_s  = lowMask(startDeg_s);
    startCrc_s   = crcIf.crcIn << (CRC_GPW_MAX - int'(startDeg_s));
  end

  // One long-division step: feedback is the remainder MSB xored with the stream bit.
  always_comb begin
    fb_s      = rem_r[deg_r - DW'(1)] ^ stream_r[SW-1];
    nextRem_s = ((rem_r << 1) & mask_r) ^ (fb_s ? taps_r : '0);
    lastCnt_s = CW'(DWIDTH) + CW'(deg_r) - CW'(1);
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r    <= IDLE;
      deg_r      <= '0;
      mask_r     <= '0;
      taps_r     <= '0;
      rem_r      <= '0;
      stream_r   <= '0;
      bitCnt_r   <= '0;
      valid_r    <= 1'b0;
      holdDone_r <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      ok_r       <= 1'b0;
      err_r      <= 1'b0;
      residue_r  <= '0;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (crcIf.ctrlEn) begin
            deg_r      <= startDeg_s;
            mask_r     <= startMask_s;
            taps_r     <= crcIf.GenPoly & startMask_s;
            rem_r      <= crcIf.initVal & startMask_s;
            stream_r   <= {crcIf.dataIn, startCrc_s};
            bitCnt_r   <= '0;
            valid_r    <= startValid_s;
            holdDone_r <= 1'b0;
            busy_r     <= 1'b1;
            ok_r       <= 1'b0;
            err_r      <= 1'b0;
            residue_r  <= '0;
            state_r    <= startValid_s ? CALC : DONE;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r    <= nextRem_s;
          stream_r <= stream_r << 1;
          bitCnt_r <= bitCnt_r + CW'(1);
          if (bitCnt_r == lastCnt_s) begin
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          // An invalid polynomial lingers one extra cycle so its error report
          // lands two edges after the start.
          if (!valid_r && !holdDone_r) begin
            holdDone_r <= 1'b1;
            state_r    <= DONE;
          end else begin
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            residue_r <= rem_r;
            ok_r      <= valid_r && (rem_r == '0);
            err_r     <= !(valid_r && (rem_r == '0));
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign crcIf.crcBusy  = busy_r;
  assign crcIf.crcReady = ready_r;
  assign crcIf.crcOk    = ok_r;
  assign crcIf.crcErr   = err_r;
  assign crcIf.residue  = residue_r;
endmodule
